// File: rtl/control_sequencer.sv
// Hard-wired T-step control sequencer: fetch (T0-T2) then execute register ALU ops.
// Outputs are Moore-decoded from the step, with IR fields steering the execute steps.
module control_sequencer #(
   parameter int NREGS = 16,
   parameter int OPW   = 5
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             run,
   input  logic [31:0]      ir,
   output logic             PCout,
   output logic             PCin,
   output logic             IncPC,
   output logic             MARin,
   output logic             Read,
   output logic             MDRin,
   output logic             MDRout,
   output logic             IRin,
   output logic             Yin,
   output logic             ZLowIn,
   output logic             ZLowOut,
   output logic [NREGS-1:0] reg_out,
   output logic [NREGS-1:0] reg_in,
   output logic [OPW-1:0]   alu_op,
   output logic             done,
   output logic             illegal
);

   typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5} state_t;

   localparam logic [OPW-1:0] OP_ADD = OPW'(5'b00011);
   localparam logic [OPW-1:0] OP_SUB = OPW'(5'b00100);
   localparam logic [OPW-1:0] OP_AND = OPW'(5'b00101);
   localparam logic [OPW-1:0] OP_OR  = OPW'(5'b00110);
   localparam logic [OPW-1:0] OP_NEG = OPW'(5'b10001);
   localparam logic [OPW-1:0] OP_NOT = OPW'(5'b10010);

   state_t state, state_nxt;

   logic [OPW-1:0]   op;
   logic [3:0]       ra, rb, rc;
   logic             is_3op, is_2op;
   logic [NREGS-1:0] sel_a, sel_b, sel_c;
   logic             unused_ir;

   assign op = ir[31 -: OPW];
   assign ra = ir[26:23];
   assign rb = ir[22:19];
   assign rc = ir[18:15];
   assign unused_ir = ^ir[14:0];

   always_comb begin
      is_3op = 1'b0;
      is_2op = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: is_3op = 1'b1;
         OP_NEG, OP_NOT:                is_2op = 1'b1;
         default: ;
      endcase
   end

   // Index decode; any index outside the register file leaves the bus all-zero.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      sel_c = '0;
      for (int i = 0; i < NREGS; i++) begin
         sel_a[i] = (int'(ra) == i);
         sel_b[i] = (int'(rb) == i);
         sel_c[i] = (int'(rc) == i);
      end
   end

   always_ff @(posedge clock) begin
      if (clear) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      PCout     = 1'b0;
      PCin      = 1'b0;
      IncPC     = 1'b0;
      MARin     = 1'b0;
      Read      = 1'b0;
      MDRin     = 1'b0;
      MDRout    = 1'b0;
      IRin      = 1'b0;
      Yin       = 1'b0;
      ZLowIn    = 1'b0;
      ZLowOut   = 1'b0;
      reg_out   = '0;
      reg_in    = '0;
      alu_op    = '0;
      done      = 1'b0;
      illegal   = 1'b0;
      case (state)
         IDLE: if (run) state_nxt = T0;
         T0: begin
            PCout     = 1'b1;
            MARin     = 1'b1;
            IncPC     = 1'b1;
            ZLowIn    = 1'b1;
            state_nxt = T1;
         end
         T1: begin
            ZLowOut   = 1'b1;
            PCin      = 1'b1;
            Read      = 1'b1;
            MDRin     = 1'b1;
            state_nxt = T2;
         end
         T2: begin
            MDRout    = 1'b1;
            IRin      = 1'b1;
            state_nxt = T3;
         end
         T3: begin
            if (is_3op) begin
               reg_out   = sel_b;
               Yin       = 1'b1;
               state_nxt = T4;
            end else if (is_2op) begin
               reg_out   = sel_b;
               alu_op    = op;
               ZLowIn    = 1'b1;
               state_nxt = T4;
            end else begin
               illegal   = 1'b1;
               state_nxt = IDLE;
            end
         end
         T4: begin
            if (is_3op) begin
               reg_out   = sel_c;
               alu_op    = op;
               ZLowIn    = 1'b1;
               state_nxt = T5;
            end else begin
               // 2-op write-back is the final step; run decides back-to-back fetch.
               ZLowOut   = 1'b1;
               reg_in    = sel_a;
               done      = 1'b1;
               state_nxt = run ? T0 : IDLE;
            end
         end
         T5: begin
            ZLowOut   = 1'b1;
            reg_in    = sel_a;
            done      = 1'b1;
            state_nxt = run ? T0 : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: checks every step's strobes against hand-derived values.
module tb_control_sequencer;

   localparam int NREGS = 16;
   localparam int OPW   = 5;

   // Strobe vector order: PCout PCin IncPC MARin Read MDRin MDRout IRin Yin ZLowIn ZLowOut done illegal
   localparam logic [12:0] S_NONE = 13'b0000000000000;
   localparam logic [12:0] S_T0   = 13'b1011000001000;
   localparam logic [12:0] S_T1   = 13'b0100110000100;
   localparam logic [12:0] S_T2   = 13'b0000001100000;
   localparam logic [12:0] S_YIN  = 13'b0000000010000;
   localparam logic [12:0] S_ZIN  = 13'b0000000001000;
   localparam logic [12:0] S_WB   = 13'b0000000000110;
   localparam logic [12:0] S_ILL  = 13'b0000000000001;

   logic             clock = 1'b0;
   logic             clear, run;
   logic [31:0]      ir;
   logic             PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
   logic             Yin, ZLowIn, ZLowOut, done, illegal;
   logic [NREGS-1:0] reg_out, reg_in;
   logic [OPW-1:0]   alu_op;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   control_sequencer #(.NREGS(NREGS), .OPW(OPW)) dut (
      .clock(clock), .clear(clear), .run(run), .ir(ir),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
      .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn),
      .ZLowOut(ZLowOut), .reg_out(reg_out), .reg_in(reg_in), .alu_op(alu_op),
      .done(done), .illegal(illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then compare every output group for the new step.
   task automatic step(input string tag, input logic [12:0] s, input logic [15:0] ro,
                       input logic [15:0] ri, input logic [4:0] alu);
      logic [12:0] got;
      int drivers;
      @(posedge clock);
      #1;
      got = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
             Yin, ZLowIn, ZLowOut, done, illegal};
      chk({tag, ".strobes"}, 32'(got), 32'(s));
      chk({tag, ".reg_out"}, 32'(reg_out), 32'(ro));
      chk({tag, ".reg_in"},  32'(reg_in),  32'(ri));
      chk({tag, ".alu_op"},  32'(alu_op),  32'(alu));
      drivers = int'(PCout) + int'(MDRout) + int'(ZLowOut) + int'(reg_out != '0);
      chk({tag, ".one_driver"}, 32'(drivers <= 1), 32'd1);
   endtask

   initial begin
      clear = 1'b1;
      run   = 1'b0;
      ir    = 32'h0;

      // 1: reset held two edges, then idle with run low
      step("rst0", S_NONE, 16'h0, 16'h0, 5'h0);
      step("rst1", S_NONE, 16'h0, 16'h0, 5'h0);
      clear = 1'b0;
      for (int i = 0; i < 5; i++) step($sformatf("idle%0d", i), S_NONE, 16'h0, 16'h0, 5'h0);

      // 2: ADD R4,R5,R7
      run = 1'b1;
      ir  = 32'h1A2B8000;
      step("add.T0", S_T0,  16'h0,    16'h0,    5'h0);
      step("add.T1", S_T1,  16'h0,    16'h0,    5'h0);
      step("add.T2", S_T2,  16'h0,    16'h0,    5'h0);
      step("add.T3", S_YIN, 16'h0020, 16'h0,    5'h0);
      step("add.T4", S_ZIN, 16'h0080, 16'h0,    5'b00011);
      step("add.T5", S_WB,  16'h0,    16'h0010, 5'h0);

      // 3: NEG R5,R5 back-to-back, then straight into the next fetch
      step("neg.T0", S_T0,  16'h0,    16'h0,    5'h0);
      ir = 32'h8AA80000;
      step("neg.T1", S_T1,  16'h0,    16'h0,    5'h0);
      step("neg.T2", S_T2,  16'h0,    16'h0,    5'h0);
      step("neg.T3", S_ZIN, 16'h0020, 16'h0,    5'b10001);
      step("neg.T4", S_WB,  16'h0,    16'h0020, 5'h0);
      step("ill.T0", S_T0,  16'h0,    16'h0,    5'h0);

      // 4: unsupported opcode 11111 aborts to IDLE after T3 even with run high
      ir = 32'hF8000000;
      step("ill.T1", S_T1,  16'h0,    16'h0,    5'h0);
      step("ill.T2", S_T2,  16'h0,    16'h0,    5'h0);
      step("ill.T3", S_ILL, 16'h0,    16'h0,    5'h0);
      step("ill.idle", S_NONE, 16'h0, 16'h0,    5'h0);

      // 5: clear during T4 of ADD kills the write-back
      ir = 32'h1A2B8000;
      step("clr.T0", S_T0,  16'h0,    16'h0,    5'h0);
      step("clr.T1", S_T1,  16'h0,    16'h0,    5'h0);
      step("clr.T2", S_T2,  16'h0,    16'h0,    5'h0);
      step("clr.T3", S_YIN, 16'h0020, 16'h0,    5'h0);
      step("clr.T4", S_ZIN, 16'h0080, 16'h0,    5'b00011);
      clear = 1'b1;
      run   = 1'b0;
      step("clr.idle0", S_NONE, 16'h0, 16'h0,   5'h0);
      clear = 1'b0;
      step("clr.idle1", S_NONE, 16'h0, 16'h0,   5'h0);

      // 6: NOT R2,R3 with run dropped in T3 still completes, then idles
      run = 1'b1;
      ir  = 32'h91180000;
      step("not.T0", S_T0,  16'h0,    16'h0,    5'h0);
      step("not.T1", S_T1,  16'h0,    16'h0,    5'h0);
      step("not.T2", S_T2,  16'h0,    16'h0,    5'h0);
      step("not.T3", S_ZIN, 16'h0008, 16'h0,    5'b10010);
      run = 1'b0;
      step("not.T4", S_WB,  16'h0,    16'h0004, 5'h0);
      step("not.idle0", S_NONE, 16'h0, 16'h0,   5'h0);
      step("not.idle1", S_NONE, 16'h0, 16'h0,   5'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
